relu_maxpool: RTL and testbench
===============================

Name: relu_maxpool

Overview:
- Downstream stage of the convolution MAC unit. Consumes the 32-bit signed convolution results it produces, in raster order over one IMG_W x IMG_H feature map.
- Applies ReLU, then 2x2 stride-2 max pooling, then right-shift requantisation with saturation to 16 bits.
- Emits one pooled 16-bit pixel per completed window, for the next layer's input buffer.
- Holds a half-width line buffer of partial row maxima.

Parameters:
- IMG_W, 8, convolution output width in pixels; must be even and >= 2.
- IMG_H, 8, convolution output height in pixels; must be even and >= 2.
- SHIFT, 0, arithmetic right shift applied to the pooled value before saturation (0..16).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_pix is valid this cycle
- in_pix  in  32 (signed)  convolution result
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_valid  out  1  out_pix holds a pooled result
- out_pix  out  16 (signed)  pooled, requantised pixel; always >= 0
- out_ready  in  1  consumer accepts out_pix when out_valid && out_ready
- out_last  out  1  qualifies out_pix as the final pooled pixel of the frame

Behaviour:
- Reset (asynchronous, active-high; clock is clk):
  - out_valid=0, out_pix=0, out_last=0.
  - col=0, row=0, hreg=0. Line buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted beat is pixel (0,0).
- in_ready = !out_valid || out_ready (combinational).
- ReLU on every accepted beat: r = (in_pix < 0) ? 0 : in_pix.
- Counters:
  - col increments per accepted beat and wraps at IMG_W-1 to 0.
  - On wrap, row increments; row wraps at IMG_H-1 to 0.
  - Counters never advance without an accepted beat.
- Row-phase FSM with 2 states, EVEN_ROW and ODD_ROW. It toggles on each col wrap and returns to EVEN_ROW at frame wrap.
  - EVEN_ROW, even col: hreg <= r.
  - EVEN_ROW, odd col: lbuf[col>>1] <= max(hreg, r).
  - ODD_ROW, even col: hreg <= r.
  - ODD_ROW, odd col: m = max(lbuf[col>>1], hreg, r); the window completes.
- Line buffer: IMG_W/2 entries x 32 bits. Written and read only at odd columns. Read of entry k in ODD_ROW always follows its write in EVEN_ROW of the same row pair.
- Requantisation on window completion:
  - q = m >>> SHIFT, computed in 32 bits (m >= 0).
  - out_pix = (q > 32767) ? 32767 : q[15:0].
- Output register:
  - On window completion, the next edge sets out_valid=1 and loads out_pix.
  - out_last = 1 iff the completing beat was (row=IMG_H-1, col=IMG_W-1).
  - Latency is 1 cycle from the accepted completing beat.
- Holding and clearing:
  - With out_valid=1 and out_ready=0: out_pix and out_last are held and in_ready=0, so the input stalls.
  - out_valid clears when out_ready=1 and no new window completes in the same cycle.
  - If out_ready=1 and a window completes in the same cycle, the register reloads and out_valid stays 1 (back-to-back).
- Output rate:
  - Pooled output count per frame is (IMG_W/2)*(IMG_H/2).
  - Frames stream continuously with no idle cycle required between them.
- in_pix is ignored when in_valid=0 or in_ready=0.
- Arithmetic:
  - Comparators are 32-bit signed; all operands are non-negative after ReLU.
  - There is no overflow path other than the saturation above.

Decomposition:
- Shared package holds:
  - PIX_IN_W=32 and PIX_OUT_W=16.
  - Row-phase enum {EVEN_ROW, ODD_ROW}.
  - Saturation limit constant 32767.
- One natural sub-module, pool_line_buffer: IMG_W/2 x 32 single-port RAM with synchronous write and combinational read, addressed by col>>1.
- ReLU, max and saturation stay inline.

Test Plan:
- IMG_W=4, IMG_H=4, SHIFT=0; stream 1..16 with out_ready=1 -> out_pix sequence 6, 8, 14, 16; out_last=1 only on 16; exactly 4 out_valid pulses.
- Same config, all inputs -5 -> four outputs of 0.
- Same config, window {-100, 3, 70000, -1} at positions (0,0),(0,1),(1,0),(1,1) -> out_pix = 32767.
- SHIFT=4, window max 4096 -> out_pix = 256; window max 15 -> out_pix = 0.
- out_ready held low for 5 cycles after the first output:
  - out_pix stays at 6 and in_ready=0.
  - No input is consumed.
  - After release, the remaining outputs are 8, 14, 16, unchanged.
- Assert rst after 5 accepted beats, then stream a full 1..16 frame -> outputs 6, 8, 14, 16; out_valid=0 during reset.
- Two frames back-to-back with in_valid held high -> 8 outputs; out_last on the 4th and 8th.

Source files
------------

// File: rtl/relu_maxpool_pkg.sv
// ============================================================================
// relu_maxpool_pkg : shared widths, row-phase encoding and max helper
// Rev 1.0
// ============================================================================
`default_nettype none

package relu_maxpool_pkg;
  localparam int PIX_IN_W  = 32;
  localparam int PIX_OUT_W = 16;
  localparam int SAT_LIMIT = 32767;

  typedef enum logic [0:0] {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_phase_t;

  function automatic logic signed [PIX_IN_W-1:0] smax(
    input logic signed [PIX_IN_W-1:0] a,
    input logic signed [PIX_IN_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction
endpackage

`default_nettype wire

// File: rtl/relu_maxpool_if.sv
// ============================================================================
// relu_maxpool_if : input pixel stream and pooled output stream handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

interface relu_maxpool_if;
  import relu_maxpool_pkg::*;

  logic                        in_valid;
  logic signed [PIX_IN_W-1:0]  in_pix;
  logic                        in_ready;
  logic                        out_valid;
  logic signed [PIX_OUT_W-1:0] out_pix;
  logic                        out_ready;
  logic                        out_last;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, out_last
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_pix, out_last
  );
endinterface

`default_nettype wire

// File: rtl/relu_maxpool_pool_line_buffer.sv
// ============================================================================
// pool_line_buffer : single-port RAM of partial row maxima, sync write,
// combinational read
// Rev 1.0
// ============================================================================
`default_nettype none

module pool_line_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

`default_nettype wire

// File: rtl/relu_maxpool.sv
// ============================================================================
// relu_maxpool : ReLU, 2x2 stride-2 max pooling and shift/saturate
// requantisation of a raster-order convolution feature map
// Rev 1.0
// ============================================================================
`default_nettype none

module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  relu_maxpool_if.slave bus
);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [0:0]    ST_EVEN = EVEN_ROW;
  localparam logic [0:0]    ST_ODD  = ODD_ROW;
  localparam logic signed [PIX_IN_W-1:0] SAT_MAX = PIX_IN_W'(SAT_LIMIT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [0:0]    state;
  logic signed [PIX_IN_W-1:0] hreg;

  logic                        out_valid_q;
  logic [PIX_OUT_W-1:0]        out_pix_q;
  logic                        out_last_q;

  logic                        accept;
  logic                        col_wrap;
  logic                        frame_wrap;
  logic                        odd_col;
  logic                        win_done;
  logic                        lbuf_we;
  logic [AW-1:0]               lbuf_addr;
  logic signed [PIX_IN_W-1:0]  relu;
  logic signed [PIX_IN_W-1:0]  lbuf_rd;
  logic signed [PIX_IN_W-1:0]  hmax;
  logic signed [PIX_IN_W-1:0]  win_max;
  logic signed [PIX_IN_W-1:0]  shifted;
  logic [PIX_OUT_W-1:0]        sat;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_last  = out_last_q;

  assign accept     = bus.in_valid && bus.in_ready;
  assign col_wrap   = (col == COL_MAX);
  assign frame_wrap = col_wrap && (row == ROW_MAX);
  assign odd_col    = col[0];
  assign relu       = bus.in_pix[PIX_IN_W-1] ? '0 : bus.in_pix;

  assign hmax     = smax(hreg, relu);
  assign win_max  = smax(lbuf_rd, hmax);
  // Window maximum is non-negative, so the arithmetic shift never goes below 0
  assign shifted  = win_max >>> SHIFT;
  assign sat      = (shifted > SAT_MAX) ? PIX_OUT_W'(SAT_LIMIT) : shifted[PIX_OUT_W-1:0];

  assign lbuf_addr = AW'(col >> 1);
  assign lbuf_we   = accept && odd_col && (state == ST_EVEN);
  assign win_done  = accept && odd_col && (state == ST_ODD);

  pool_line_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_IN_W),
    .AW    (AW)
  ) u_lbuf (
    .clk   (clk),
    .we    (lbuf_we),
    .addr  (lbuf_addr),
    .wdata (hmax),
    .rdata (lbuf_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      state <= ST_EVEN;
      hreg  <= '0;
    end else if (accept) begin
      col <= col_wrap ? '0 : col + CW'(1);
      if (col_wrap) begin
        row   <= (row == ROW_MAX) ? '0 : row + RW'(1);
        state <= frame_wrap ? ST_EVEN : ~state;
      end
      if (!odd_col) hreg <= relu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (win_done) begin
      out_valid_q <= 1'b1;
      out_pix_q   <= sat;
      out_last_q  <= frame_wrap;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool.sv
// ============================================================================
// tb_relu_maxpool : directed bench for relu_maxpool, 4x4 maps, SHIFT 0 and 4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_relu_maxpool;
  import relu_maxpool_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic signed [31:0] in_pix = '0;
  logic out_ready = 1'b1;

  always #5 clk = ~clk;

  relu_maxpool_if if0 ();
  relu_maxpool_if if4 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_pix    = in_pix;
  assign if0.out_ready = out_ready;
  assign if4.in_valid  = in_valid;
  assign if4.in_pix    = in_pix;
  assign if4.out_ready = out_ready;

  relu_maxpool #(.IMG_W(4), .IMG_H(4), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  relu_maxpool #(.IMG_W(4), .IMG_H(4), .SHIFT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int n_assert = 0;
  int n_fail   = 0;
  int q0[$];
  int q4[$];
  int ql[$];
  int beats = 0;
  int frame [16];
  int exp0  [8];
  int exp4  [8];
  int expl  [8];

  task automatic check(input string tag, input int obs, input int exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if0.out_valid && out_ready) begin
        q0.push_back(int'(if0.out_pix));
        q4.push_back(int'(if4.out_pix));
        ql.push_back(int'(if0.out_last));
      end
      if (in_valid && if0.in_ready) beats = beats + 1;
    end
  end

  task automatic send(input int v);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_pix   = v;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = if0.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_accept", int'(acc), 1);
  endtask

  task automatic stream_frame();
    for (int i = 0; i < 16; i++) send(frame[i]);
  endtask

  task automatic check_out(input string tag, input int n);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, q0.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < q0.size()) begin
        check($sformatf("%s_pix0[%0d]", tag, i), q0[i], exp0[i]);
        check($sformatf("%s_pix4[%0d]", tag, i), q4[i], exp4[i]);
        check($sformatf("%s_last[%0d]", tag, i), ql[i], expl[i]);
      end
    end
    q0.delete();
    q4.delete();
    ql.delete();
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < 16; i++) frame[i] = i + 1;
    exp0 = '{6, 8, 14, 16, 6, 8, 14, 16};
    exp4 = '{0, 0, 0, 1, 0, 0, 0, 1};
    expl = '{0, 0, 0, 1, 0, 0, 0, 1};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(if0.out_valid), 0);
    check("rst_out_pix",   int'(if0.out_pix), 0);
    check("rst_out_last",  int'(if0.out_last), 0);
    check("rst_in_ready",  int'(if0.in_ready), 1);
    @(posedge clk); #1 rst = 1'b0;

    // Ramp frame, consumer always ready
    ramp_frame();
    stream_frame();
    in_valid = 1'b0;
    check_out("ramp", 4);

    // All negative inputs
    for (int i = 0; i < 16; i++) frame[i] = -5;
    exp0 = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp4 = '{0, 0, 0, 0, 0, 0, 0, 0};
    stream_frame();
    in_valid = 1'b0;
    check_out("neg", 4);

    // Saturation on the first window
    frame = '{-100, 3, 0, 0, 70000, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp0  = '{32767, 0, 0, 0, 0, 0, 0, 0};
    exp4  = '{4375, 0, 0, 0, 0, 0, 0, 0};
    stream_frame();
    in_valid = 1'b0;
    check_out("sat", 4);

    // Shift requantisation: maxima 4096, 15, 16, 100
    frame = '{4096, 1, 15, 2, 3, 4, 0, 7, 16, 0, 0, 100, 0, 0, 0, 0};
    exp0  = '{4096, 15, 16, 100, 0, 0, 0, 0};
    exp4  = '{256, 0, 1, 6, 0, 0, 0, 0};
    stream_frame();
    in_valid = 1'b0;
    check_out("shift", 4);

    // Backpressure after the first output
    ramp_frame();
    beats = 0;
    out_ready = 1'b0;
    fork
      stream_frame();
      begin
        logic seen;
        int snap;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = if0.out_valid;
        end
        check("bp_seen_valid", int'(seen), 1);
        snap = beats;
        check("bp_beats_at_stall", snap, 6);
        for (int i = 0; i < 5; i++) begin
          check("bp_hold_pix",   int'(if0.out_pix), 6);
          check("bp_hold_valid", int'(if0.out_valid), 1);
          check("bp_in_ready",   int'(if0.in_ready), 0);
          @(negedge clk);
        end
        check("bp_no_consume", beats, snap);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    check_out("bp", 4);

    // Reset in the middle of a frame
    for (int i = 1; i <= 5; i++) send(i);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid0", int'(if0.out_valid), 0);
    check("mid_rst_valid4", int'(if4.out_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    q0.delete();
    q4.delete();
    ql.delete();
    ramp_frame();
    stream_frame();
    in_valid = 1'b0;
    check_out("mid_rst", 4);

    // Two frames back to back with in_valid held high
    ramp_frame();
    beats = 0;
    stream_frame();
    stream_frame();
    in_valid = 1'b0;
    check("b2b_beats", beats, 32);
    check_out("b2b", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
